// File: rtl/pkt_sche_enq_gen.sv
// Enqueue-side traffic source for pkt_sche: bursts of LFSR-prioritised
// packets with periodic urgent flags, driven against the scheduler ready.
module pkt_sche_enq_gen #(
  parameter int DWIDTH           = 32,
  parameter int PRIO_W           = 8,
  parameter int INFO_W           = 8,
  parameter int CNT_W            = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_pkts,
  input  logic [CNT_W-1:0]  ugr_period,
  input  logic              sch_ready,
  output logic              sch_in_valid,
  output logic              sch_in_enque_en,
  output logic              sch_in_ugr_en,
  output logic [INFO_W-1:0] sch_in_pkt_info,
  output logic [DWIDTH-1:0] sch_in_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t           state, state_nx;
  logic [15:0]      lfsr, lfsr_nx;
  logic [CNT_W-1:0] seq, num_r, per_r, ugr_cnt;
  logic             acc, start_ok, last;

  assign acc      = (state == SEND) && sch_ready;
  assign start_ok = start && (state != SEND);
  assign last     = (seq == num_r - ONE);
  assign lfsr_nx  = {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    sch_in_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (num_pkts == '0) ? FIN : SEND;
      end
      SEND: begin
        sch_in_valid = 1'b1;
        busy         = 1'b1;
        if (abort || (sch_ready && last))
          state_nx = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (start)
          state_nx = (num_pkts == '0) ? FIN : SEND;
        else
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ugr_cnt counts packets left until the next urgent one
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= LFSR_SEED;
      seq     <= '0;
      num_r   <= '0;
      per_r   <= '0;
      ugr_cnt <= '0;
    end else if (start_ok) begin
      seq     <= '0;
      num_r   <= num_pkts;
      per_r   <= ugr_period;
      ugr_cnt <= ugr_period;
    end else if (acc) begin
      seq     <= seq + ONE;
      lfsr    <= lfsr_nx;
      ugr_cnt <= (ugr_cnt == ONE) ? per_r : ugr_cnt - ONE;
    end
  end

  assign sent_cnt        = seq;
  assign sch_in_enque_en = sch_in_valid;
  assign sch_in_ugr_en   = sch_in_valid && (per_r != '0) &&
                           (ugr_cnt == ONE);

  always_comb begin
    sch_in_data = '0;
    if (sch_in_valid) begin
      sch_in_data[CNT_W-1:0]          = seq;
      sch_in_data[DWIDTH-1 -: PRIO_W] = lfsr[PRIO_W-1:0];
    end
  end

  generate
    if (CNT_W >= INFO_W) begin : g_info_trunc
      assign sch_in_pkt_info = sch_in_valid ? seq[INFO_W-1:0] : '0;
    end else begin : g_info_ext
      assign sch_in_pkt_info = sch_in_valid ?
        {{(INFO_W-CNT_W){1'b0}}, seq} : '0;
    end
  endgenerate

endmodule

// File: tb/tb_pkt_sche_enq_gen.sv
// Directed bench for pkt_sche_enq_gen: transaction model of the
// expected packet stream plus per-cycle protocol checks.
module tb_pkt_sche_enq_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_pkts = '0;
  logic [15:0] ugr_period = '0;
  logic        ready = 1'b0;
  logic        valid, enq, ugr, busy, done;
  logic [7:0]  info;
  logic [31:0] data;
  logic [15:0] sent_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pkt_sche_enq_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_pkts(num_pkts), .ugr_period(ugr_period),
    .sch_ready(ready), .sch_in_valid(valid),
    .sch_in_enque_en(enq), .sch_in_ugr_en(ugr),
    .sch_in_pkt_info(info), .sch_in_data(data),
    .busy(busy), .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // model of the packet stream
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_k, m_num, m_period;
  int          acc_cnt;
  logic [31:0] acc_data [0:15];
  logic [15:0] ugr_bits;
  logic        prev_stall = 1'b0;
  logic        prev_abort = 1'b0;
  logic [40:0] prev_vals;

  always @(negedge clk) begin
    if (rst) begin
      m_lfsr     = 16'hACE1;
      prev_stall = 1'b0;
    end else begin
      chk("enq_eq_valid", 64'(enq), 64'(valid));
      chk("busy_eq_valid", 64'(busy), 64'(valid));
      if (!valid)
        chk("idle_zero", 64'({ugr, info, data}), 64'd0);
      if (prev_stall) begin
        if (valid)
          chk("hold", 64'({ugr, info, data}), 64'(prev_vals));
        else if (!prev_abort) begin
          n_checks++;
          n_errors++;
          $display("FAIL valid_drop: valid 0 during stall, required 1");
        end
      end
      if (valid && ready) begin
        logic [40:0] exp;
        logic        e_ugr;
        if (m_k >= m_num) begin
          n_errors++;
          $display("FAIL extra_accept: packet %0d of %0d", m_k, m_num);
        end
        e_ugr = (m_period != 0) && (((m_k + 1) % m_period) == 0);
        exp = {e_ugr, 8'(m_k), m_lfsr[7:0], 8'h00, 16'(m_k)};
        chk("pkt", 64'({ugr, info, data}), 64'(exp));
        if (acc_cnt < 16) begin
          acc_data[acc_cnt] = data;
          ugr_bits[acc_cnt] = ugr;
        end
        acc_cnt++;
        m_k++;
        m_lfsr = lfsr_step(m_lfsr);
      end
      prev_stall = valid && !ready;
      prev_vals  = {ugr, info, data};
      prev_abort = abort;
    end
  end

  // called at posedge+1; returns at posedge+1 of first SEND/FIN cycle
  task automatic start_burst(int n, int p);
    num_pkts   = 16'(n);
    ugr_period = 16'(p);
    m_k        = 0;
    m_num      = n;
    m_period   = p;
    acc_cnt    = 0;
    ugr_bits   = '0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // drives ready from a 4-cycle pattern until done seen at a negedge
  task automatic run_until_done(logic [3:0] pat, int bound);
    bit found = 0;
    for (int i = 0; i < bound; i++) begin
      ready = pat[i % 4];
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL done_timeout: no done within %0d cycles", bound);
    end
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 64'({done, busy, valid}), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_state", 64'({valid, busy, done, sent_cnt, data}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: four back-to-back packets
    start_burst(4, 0);
    run_until_done(4'b1111, 40);
    chk("t1_sent", 64'(sent_cnt), 64'd4);
    chk("t1_acc", 64'(acc_cnt), 64'd4);
    chk("t1_p0", 64'(acc_data[0]), 64'h E100_0000);
    chk("t1_p1", 64'(acc_data[1]), 64'h C300_0001);
    chk("t1_p2", 64'(acc_data[2]), 64'h 8700_0002);

    // 2: stalls with pattern 1,0,0,1
    start_burst(3, 0);
    run_until_done(4'b1001, 40);
    chk("t2_acc", 64'(acc_cnt), 64'd3);
    chk("t2_sent", 64'(sent_cnt), 64'd3);

    // 3: urgent every third packet
    start_burst(6, 3);
    run_until_done(4'b1111, 40);
    chk("t3_ugr", 64'(ugr_bits[5:0]), 64'b100100);
    chk("t3_sent", 64'(sent_cnt), 64'd6);

    // 4: empty burst, done right after start
    start_burst(0, 0);
    @(negedge clk);
    chk("t4_done", 64'({done, valid}), 64'b10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_after", 64'({done, valid, sent_cnt}), 64'd0);
    @(posedge clk); #1;

    // 5: abort together with fourth accept
    ready = 1'b1;
    start_burst(10, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    chk("t5_state", 64'({valid, done}), 64'b01);
    chk("t5_sent", 64'(sent_cnt), 64'd4);
    chk("t5_acc", 64'(acc_cnt), 64'd4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_pulse", 64'(done), 64'd0);
    @(posedge clk); #1;

    // 6: reset mid-burst
    ready = 1'b1;
    start_burst(8, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_zero", 64'({valid, busy, done, ugr, info, data}), 64'd0);
    chk("t6_sent", 64'(sent_cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_no_done", 64'({done, valid}), 64'd0);
    end
    @(posedge clk); #1;
    start_burst(2, 0);
    run_until_done(4'b1111, 20);
    chk("t6_reseed", 64'(acc_data[0]), 64'h E100_0000);
    chk("t6_sent2", 64'(sent_cnt), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
